bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/arb_mux.sv | 23 ++
 rtl/bus_arbiter.sv | 91 +++++++++
 tb/tb_bus_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the two-master bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam int MAX_HOLD_DEF = 16;

    // Slave-side payload: {wr, addr[7:0], dout[31:0]}
    localparam int PAYLOAD_W = 41;

endpackage

// File: rtl/arb_mux.sv
// Slave-side payload select: owner 0, owner 1, or all-zero when nobody owns the bus.
module arb_mux
    import bus_arbiter_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         sel0,
    input  logic         sel1,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    always_comb begin
        out = '0;
        unique case (1'b1)
            sel0:    out = in0;
            sel1:    out = in1;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: M0 priority from idle, bounded hold under contention.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M0_req,
    input  logic        M0_wr,
    input  logic [7:0]  M0_addr,
    input  logic [31:0] M0_dout,
    input  logic        M1_req,
    input  logic        M1_wr,
    input  logic [7:0]  M1_addr,
    input  logic [31:0] M1_dout,
    output logic        M0_grant,
    output logic        M1_grant,
    output logic        S_wr,
    output logic [7:0]  S_addr,
    output logic [31:0] S_din
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nx;
    logic       other_req;

    logic [PAYLOAD_W-1:0] s_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        hold_nx   = '0;
        other_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (M0_req)
                    state_nx = GNT0;
                else if (M1_req)
                    state_nx = GNT1;
            end
            GNT0: begin
                other_req = M1_req;
                if (!M0_req)
                    state_nx = M1_req ? GNT1 : IDLE;
                else if (M1_req && hold_cnt == HOLD_LAST)
                    state_nx = GNT1;
            end
            GNT1: begin
                other_req = M0_req;
                if (!M1_req)
                    state_nx = M0_req ? GNT0 : IDLE;
                else if (M0_req && hold_cnt == HOLD_LAST)
                    state_nx = GNT0;
            end
            default: state_nx = IDLE;
        endcase
        // Count only contested cycles within one tenure
        if (state_nx == state && state != IDLE && other_req)
            hold_nx = hold_cnt + 8'd1;
    end

    assign M0_grant = (state == GNT0);
    assign M1_grant = (state == GNT1);

    arb_mux #(
        .W(PAYLOAD_W)
    ) u_mux (
        .sel0 (M0_grant),
        .sel1 (M1_grant),
        .in0  ({M0_wr, M0_addr, M0_dout}),
        .in1  ({M1_wr, M1_addr, M1_dout}),
        .out  (s_bus)
    );

    assign {S_wr, S_addr, S_din} = s_bus;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against an ownership model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        M0_req, M0_wr, M1_req, M1_wr;
    logic [7:0]  M0_addr, M1_addr;
    logic [31:0] M0_dout, M1_dout;
    logic        M0_grant, M1_grant, S_wr;
    logic [7:0]  S_addr;
    logic [31:0] S_din;

    int vectors = 0;
    int errors  = 0;

    // Model: owner is -1 (nobody), 0 or 1; held counts contested cycles
    int owner = -1;
    int held  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(MAX_HOLD_DEF)) dut (
        .clk      (clk),
        .reset    (reset),
        .M0_req   (M0_req),
        .M0_wr    (M0_wr),
        .M0_addr  (M0_addr),
        .M0_dout  (M0_dout),
        .M1_req   (M1_req),
        .M1_wr    (M1_wr),
        .M1_addr  (M1_addr),
        .M1_dout  (M1_dout),
        .M0_grant (M0_grant),
        .M1_grant (M1_grant),
        .S_wr     (S_wr),
        .S_addr   (S_addr),
        .S_din    (S_din)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [7:0] a0,
                         input logic [31:0] d0, input bit r1, input bit w1,
                         input logic [7:0] a1, input logic [31:0] d1);
        M0_req = r0; M0_wr = w0; M0_addr = a0; M0_dout = d0;
        M1_req = r1; M1_wr = w1; M1_addr = a1; M1_dout = d1;
    endtask

    task automatic tick();
        int  nxt;
        int  nh;
        bit  mine;
        bit  theirs;
        logic [40:0] exp_bus;
        mine   = (owner == 0) ? M0_req : (owner == 1) ? M1_req : 1'b0;
        theirs = (owner == 0) ? M1_req : (owner == 1) ? M0_req : 1'b0;
        if (reset)
            nxt = -1;
        else if (owner < 0)
            nxt = M0_req ? 0 : (M1_req ? 1 : -1);
        else if (!mine)
            nxt = theirs ? 1 - owner : -1;
        else if (theirs && held == MAX_HOLD_DEF - 1)
            nxt = 1 - owner;
        else
            nxt = owner;
        if (reset || nxt != owner || nxt < 0)
            nh = 0;
        else
            nh = theirs ? held + 1 : 0;
        @(posedge clk);
        #1;
        owner = nxt;
        held  = nh;
        chk("m0_grant", 64'(M0_grant), 64'(owner == 0));
        chk("m1_grant", 64'(M1_grant), 64'(owner == 1));
        if (owner == 0)
            exp_bus = {M0_wr, M0_addr, M0_dout};
        else if (owner == 1)
            exp_bus = {M1_wr, M1_addr, M1_dout};
        else
            exp_bus = '0;
        chk("s_bus", 64'({S_wr, S_addr, S_din}), 64'(exp_bus));
    endtask

    initial begin
        int  cnt;
        int  gap;
        bit  r0;
        bit  r1;
        reset = 1'b1;
        drive(1, 1, 8'h11, 32'h1111_1111, 1, 1, 8'h22, 32'h2222_2222);
        tick();
        tick();
        chk("rst_grants", 64'({M0_grant, M1_grant}), 64'd0);
        chk("rst_sbus", 64'({S_wr, S_addr, S_din}), 64'd0);

        // M1 alone
        reset = 1'b0;
        drive(0, 0, 8'h00, 32'h0, 1, 1, 8'h30, 32'hCAFE_0001);
        tick();
        chk("m1_alone_gnt", 64'(M1_grant), 64'd1);
        chk("m1_alone_m0", 64'(M0_grant), 64'd0);
        chk("m1_alone_addr", 64'(S_addr), 64'h30);
        chk("m1_alone_wr", 64'(S_wr), 64'd1);

        // idle with nonzero master data
        drive(0, 1, 8'hAA, 32'hDEAD_BEEF, 0, 1, 8'h55, 32'h1234_5678);
        tick();
        chk("idle_wr", 64'(S_wr), 64'd0);
        chk("idle_addr", 64'(S_addr), 64'd0);
        chk("idle_din", 64'(S_din), 64'd0);

        // simultaneous request from idle, then M0 hogs
        drive(1, 1, 8'h01, 32'hA, 1, 0, 8'h02, 32'hB);
        tick();
        chk("tie_m0", 64'(M0_grant), 64'd1);
        chk("tie_m1", 64'(M1_grant), 64'd0);
        cnt = 0;
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt++;
            if (!M0_grant && !M1_grant)
                gap++;
            if (M1_grant)
                break;
        end
        chk("hold_len", 64'(cnt), 64'(MAX_HOLD_DEF));
        chk("hold_gap", 64'(gap), 64'd0);

        // owner drops with other waiting
        drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
        tick();
        drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
        tick();
        chk("g0_setup", 64'(M0_grant), 64'd1);
        drive(0, 0, 8'h10, 32'h0, 1, 0, 8'h5C, 32'h77);
        tick();
        chk("handover_gnt", 64'(M1_grant), 64'd1);
        chk("handover_addr", 64'(S_addr), 64'h5C);

        // reset mid-grant
        drive(0, 0, 8'h10, 32'h0, 1, 1, 8'h5C, 32'h77);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_gnt", 64'({M0_grant, M1_grant}), 64'd0);
        chk("rst_mid_bus", 64'({S_wr, S_addr, S_din}), 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_release", 64'(M1_grant), 64'd1);

        // random traffic: sticky requests give long contested stretches
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r0 = ~r0;
            if ($urandom_range(0, 9) == 0) r1 = ~r1;
            reset = ($urandom_range(0, 299) == 0);
            drive(r0, 1'($urandom), 8'($urandom), $urandom,
                  r1, 1'($urandom), 8'($urandom), $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
